// File: rtl/rom_boot_loader.sv
// Boot-path front end: queues ioctl ROM bytes, maps them to SDRAM pages and
// issues ce_ref-paced boot writes, mirroring expansion ROMs into both banks.
module rom_boot_loader #(
   parameter int         FIFO_DEPTH  = 4,
   parameter logic [8:0] OS_PAGE     = 9'h000,
   parameter logic [8:0] BASIC_PAGE  = 9'h100,
   parameter logic [8:0] AMSDOS_PAGE = 9'h107,
   parameter logic [8:0] MF2_PAGE    = 9'h0ff
) (
   input  logic         clk_sys,
   input  logic         reset,
   input  logic         ce_ref,
   input  logic         ioctl_download,
   input  logic         ioctl_wr,
   input  logic [7:0]   ioctl_index,
   input  logic [24:0]  ioctl_addr,
   input  logic [7:0]   ioctl_dout,
   input  logic [8:0]   exp_page,
   output logic         ioctl_wait,
   output logic         boot_wr,
   output logic [22:0]  boot_a,
   output logic [1:0]   boot_bank,
   output logic [7:0]   boot_dout,
   output logic [255:0] rom_map,
   output logic         load_done,
   output logic         overflow
);

   // state  | meaning
   // IDLE   | waiting for a queued byte; pops it when the FIFO is non-empty
   // BANK0  | write held on bank 0 until the ce_ref cycle
   // BANK1  | mirror write held on bank 1 until the ce_ref cycle
   // COMMIT | write finished; records high pages in rom_map
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BANK0  = 2'd1,
      ST_BANK1  = 2'd2,
      ST_COMMIT = 2'd3
   } state_t;

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] DEPTH_M1  = CW'(FIFO_DEPTH - 1);

   state_t         state;
   logic [31:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [CW-1:0]  count;
   logic           cur_dual;
   logic           dl_q;
   logic           done_pend;

   logic           map_ok;
   logic [8:0]     map_page;
   logic           map_dual;
   logic           byte_in;
   logic           full;
   logic           empty;
   logic           push;
   logic           pop;
   logic [31:0]    head;

   always_comb begin
      map_ok   = 1'b0;
      map_page = 9'h000;
      map_dual = (ioctl_index[7:6] == 2'b01);
      if (ioctl_index == 8'h00) begin
         // only the four 16K system blocks are loaded; the tail of the image is swallowed
         if (ioctl_addr[24:16] == 9'h000) begin
            map_ok = 1'b1;
            case (ioctl_addr[15:14])
               2'd0:    map_page = OS_PAGE;
               2'd1:    map_page = BASIC_PAGE;
               2'd2:    map_page = AMSDOS_PAGE;
               default: map_page = MF2_PAGE;
            endcase
         end
      end else if (ioctl_index[4:0] >= 5'd1 && ioctl_index[4:0] <= 5'd3) begin
         map_ok   = 1'b1;
         map_page = exp_page + {1'b0, ioctl_addr[21:14]};
         map_dual = 1'b1;
      end else if (ioctl_index[4:0] == 5'd5 || ioctl_index[4:0] == 5'd6) begin
         map_ok   = 1'b1;
         map_page = {1'b1, ioctl_addr[21:14]};
      end
   end

   assign byte_in = ioctl_wr & ioctl_download & map_ok;
   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign push    = byte_in & ~full;
   assign pop     = (state == ST_IDLE) & ~empty;
   assign head    = fifo_mem[rd_ptr];

   // dl_q & ~ioctl_download covers a fall seen while already idle and drained
   assign load_done = ~reset & ~ioctl_download & (done_pend | dl_q)
                      & (state == ST_IDLE) & empty;

   always_ff @(posedge clk_sys) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {map_page, ioctl_addr[13:0], map_dual, ioctl_dout};
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state      <= ST_IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         cur_dual   <= 1'b0;
         dl_q       <= 1'b0;
         done_pend  <= 1'b0;
         ioctl_wait <= 1'b0;
         boot_wr    <= 1'b0;
         boot_a     <= '0;
         boot_bank  <= 2'b00;
         boot_dout  <= '0;
         rom_map    <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (byte_in && full) overflow <= 1'b1;
         ioctl_wait <= (count >= DEPTH_M1) | ((state != ST_IDLE) & full);

         dl_q <= ioctl_download;
         if (ioctl_download || load_done) begin
            done_pend <= 1'b0;
         end else if (dl_q) begin
            done_pend <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (!empty) begin
                  boot_a    <= head[31:9];
                  boot_dout <= head[7:0];
                  cur_dual  <= head[8];
                  boot_bank <= 2'b00;
                  boot_wr   <= 1'b1;
                  state     <= ST_BANK0;
               end
            end
            ST_BANK0: begin
               if (ce_ref && boot_wr) begin
                  if (cur_dual) begin
                     boot_bank <= 2'b01;
                     state     <= ST_BANK1;
                  end else begin
                     boot_wr <= 1'b0;
                     state   <= ST_COMMIT;
                  end
               end
            end
            ST_BANK1: begin
               if (ce_ref) begin
                  boot_wr <= 1'b0;
                  state   <= ST_COMMIT;
               end
            end
            default: begin
               if (boot_a[22]) rom_map[boot_a[21:14]] <= 1'b1;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rom_boot_loader.sv
// Self-checking bench for rom_boot_loader: expected boot writes are queued as
// bytes are sent and matched in order as each write completes on ce_ref.
module tb_rom_boot_loader;

   logic         clk_sys = 1'b0;
   logic         reset = 1'b1;
   logic         ce_ref = 1'b0;
   logic         ioctl_download = 1'b0;
   logic         ioctl_wr = 1'b0;
   logic [7:0]   ioctl_index = 8'h00;
   logic [24:0]  ioctl_addr = '0;
   logic [7:0]   ioctl_dout = 8'h00;
   logic [8:0]   exp_page = 9'h000;
   logic         ioctl_wait;
   logic         boot_wr;
   logic [22:0]  boot_a;
   logic [1:0]   boot_bank;
   logic [7:0]   boot_dout;
   logic [255:0] rom_map;
   logic         load_done;
   logic         overflow;

   int errors = 0;
   int checks = 0;
   logic [32:0] sb [$];
   int wr_seen = 0;
   int cyc = 0;
   int commit_cyc = -1;
   int ld_count = 0;
   int ld_cyc = -1;
   logic prev_wr = 1'b0;
   logic prev_ce = 1'b0;
   logic [32:0] prev_vec = '0;

   rom_boot_loader dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ce_ref         (ce_ref),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_index    (ioctl_index),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .exp_page       (exp_page),
      .ioctl_wait     (ioctl_wait),
      .boot_wr        (boot_wr),
      .boot_a         (boot_a),
      .boot_bank      (boot_bank),
      .boot_dout      (boot_dout),
      .rom_map        (rom_map),
      .load_done      (load_done),
      .overflow       (overflow)
   );

   always #5 clk_sys = ~clk_sys;

   // ce_ref: one cycle in eight
   initial begin
      int n;
      n = 0;
      forever begin
         @(posedge clk_sys);
         #1;
         ce_ref = (n % 8 == 7);
         n++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1);
   end

   // completed writes are popped from the scoreboard and compared
   always @(negedge clk_sys) begin
      logic [32:0] vec;
      logic [32:0] exp_vec;
      cyc++;
      vec = {boot_bank, boot_a, boot_dout};
      if (reset) begin
         prev_wr = 1'b0;
         prev_ce = 1'b0;
      end else begin
         if (prev_wr && boot_wr && !prev_ce) begin
            checks++;
            if (vec !== prev_vec) begin
               errors++;
               $display("FAIL write_stable: got %h while held, required %h", vec, prev_vec);
            end
         end
         if (boot_wr && ce_ref) begin
            wr_seen++;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL write_unexpected: got %h, required no write", vec);
            end else begin
               exp_vec = sb.pop_front();
               if (vec !== exp_vec) begin
                  errors++;
                  $display("FAIL write_data: got %h required %h", vec, exp_vec);
               end
            end
         end
         if (prev_wr && !boot_wr) commit_cyc = cyc;
         if (load_done) begin
            ld_count++;
            ld_cyc = cyc;
         end
         prev_wr  = boot_wr;
         prev_ce  = ce_ref;
         prev_vec = vec;
      end
   end

   task automatic send_byte(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] d,
                            input bit ok, input logic [8:0] pg, input bit dual);
      @(posedge clk_sys);
      #1;
      ioctl_wr    = 1'b1;
      ioctl_index = idx;
      ioctl_addr  = addr;
      ioctl_dout  = d;
      if (ok) begin
         sb.push_back({2'b00, pg, addr[13:0], d});
         if (dual) sb.push_back({2'b01, pg, addr[13:0], d});
      end
   endtask

   task automatic end_wr();
      @(posedge clk_sys);
      #1;
      ioctl_wr = 1'b0;
   endtask

   task automatic drain(input string name);
      int budget;
      budget = 0;
      while ((sb.size() != 0 || boot_wr) && budget < 2000) begin
         @(negedge clk_sys);
         budget++;
      end
      checks++;
      if (budget >= 2000) begin
         errors++;
         $display("FAIL %s_drain: timeout with %0d writes outstanding, required 0", name, sb.size());
      end
      repeat (3) @(posedge clk_sys);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      checks++;
      if (boot_wr !== 1'b0) begin errors++; $display("FAIL reset_boot_wr: got %b required 0", boot_wr); end
      checks++;
      if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL reset_wait: got %b required 0", ioctl_wait); end
      checks++;
      if (rom_map !== '0) begin errors++; $display("FAIL reset_rom_map: got %h required 0", rom_map); end
      checks++;
      if ({overflow, load_done} !== 2'b00) begin
         errors++; $display("FAIL reset_flags: got %b required 00", {overflow, load_done});
      end
      checks++;
      if ({boot_bank, boot_a, boot_dout} !== 33'h0) begin
         errors++; $display("FAIL reset_bus: got %h required 0", {boot_bank, boot_a, boot_dout});
      end
      @(posedge clk_sys);
      #1;
      reset = 1'b0;
      ioctl_download = 1'b1;
      repeat (2) @(posedge clk_sys);
      #1;
   endtask

   task automatic test_expansion();
      int b;
      exp_page = 9'h107;
      send_byte(8'h01, 25'h0000123, 8'h3C, 1, 9'h107, 1);
      end_wr();
      b = 0;
      do begin
         @(negedge clk_sys);
         b++;
      end while (!(boot_wr && boot_bank == 2'b01) && b < 200);
      checks++;
      if (b >= 200) begin
         errors++; $display("FAIL exp_bank1_seen: timeout, bank %b required 01", boot_bank);
      end else if (rom_map[8'h07] !== 1'b0) begin
         errors++; $display("FAIL exp_map_early: got %b during bank1 required 0", rom_map[8'h07]);
      end
      drain("exp");
      checks++;
      if (rom_map[8'h07] !== 1'b1) begin errors++; $display("FAIL exp_map: got %b required 1", rom_map[8'h07]); end
      // exp_page + block wraps modulo 512
      exp_page = 9'h1F0;
      send_byte(8'h02, 25'h0080005, 8'h5A, 1, 9'h010, 1);
      send_byte(8'h23, 25'h0000000, 8'hC3, 1, 9'h1F0, 1);
      end_wr();
      drain("exp_wrap");
      checks++;
      if ({rom_map[8'hF0], rom_map[8'h10]} !== 2'b10) begin
         errors++; $display("FAIL exp_wrap_map: got %b required 10", {rom_map[8'hF0], rom_map[8'h10]});
      end
   endtask

   task automatic test_system_image();
      send_byte(8'h00, 25'h0004000, 8'hA5, 1, 9'h100, 0);
      end_wr();
      drain("sys_basic");
      checks++;
      if (rom_map[8'h00] !== 1'b1) begin errors++; $display("FAIL sys_map: got %b required 1", rom_map[8'h00]); end
      send_byte(8'h00, 25'h0000010, 8'h11, 1, 9'h000, 0);
      send_byte(8'h00, 25'h000C3FF, 8'h22, 1, 9'h0FF, 0);
      send_byte(8'h00, 25'h000BFFF, 8'h33, 1, 9'h107, 0);
      end_wr();
      drain("sys_blocks");
      checks++;
      if (rom_map[8'hFF] !== 1'b0) begin errors++; $display("FAIL sys_low_page_map: got %b required 0", rom_map[8'hFF]); end
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL sys_overflow: got %b required 0", overflow); end
   endtask

   task automatic test_plus();
      send_byte(8'h05, 25'h00482AB, 8'h77, 1, 9'h112, 0);
      send_byte(8'h46, 25'h000C001, 8'h88, 1, 9'h103, 1);
      end_wr();
      drain("plus");
      checks++;
      if ({rom_map[8'h12], rom_map[8'h03]} !== 2'b11) begin
         errors++; $display("FAIL plus_map: got %b required 11", {rom_map[8'h12], rom_map[8'h03]});
      end
   endtask

   task automatic test_ignored();
      int w0;
      bit saw_wait;
      w0 = wr_seen;
      saw_wait = 0;
      send_byte(8'h00, 25'h0010000, 8'hEE, 0, 9'h000, 0);
      send_byte(8'h00, 25'h001FFFF, 8'hEE, 0, 9'h000, 0);
      send_byte(8'h04, 25'h0000000, 8'hEE, 0, 9'h000, 0);
      send_byte(8'h07, 25'h0004000, 8'hEE, 0, 9'h000, 0);
      end_wr();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_sys);
         if (ioctl_wait) saw_wait = 1;
      end
      checks++;
      if (wr_seen != w0) begin errors++; $display("FAIL ignored_writes: got %0d writes required 0", wr_seen - w0); end
      checks++;
      if (saw_wait) begin errors++; $display("FAIL ignored_wait: got wait high required low"); end
      @(posedge clk_sys);
      #1;
   endtask

   task automatic test_burst_obey();
      int w0;
      int sent;
      int budget;
      bit saw_wait;
      logic [24:0] a;
      w0 = wr_seen;
      sent = 0;
      budget = 0;
      saw_wait = 0;
      exp_page = 9'h020;
      while (sent < 8 && budget < 1000) begin
         @(posedge clk_sys);
         #1;
         budget++;
         if (ioctl_wait) begin
            saw_wait = 1;
            ioctl_wr = 1'b0;
         end else begin
            a = (25'(sent) << 14) | 25'(sent * 3);
            ioctl_wr    = 1'b1;
            ioctl_index = 8'h01;
            ioctl_addr  = a;
            ioctl_dout  = 8'h40 + 8'(sent);
            sb.push_back({2'b00, 9'h020 + 9'(sent), a[13:0], 8'h40 + 8'(sent)});
            sb.push_back({2'b01, 9'h020 + 9'(sent), a[13:0], 8'h40 + 8'(sent)});
            sent++;
         end
      end
      end_wr();
      drain("obey");
      checks++;
      if (sent != 8) begin errors++; $display("FAIL obey_sent: got %0d bytes required 8", sent); end
      checks++;
      if (!saw_wait) begin errors++; $display("FAIL obey_wait: got wait never high required high"); end
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL obey_overflow: got %b required 0", overflow); end
      checks++;
      if (wr_seen - w0 != 16) begin errors++; $display("FAIL obey_count: got %0d writes required 16", wr_seen - w0); end
   endtask

   task automatic test_burst_overflow();
      int w0;
      logic [24:0] a;
      w0 = wr_seen;
      exp_page = 9'h040;
      // byte 0 is popped at once and byte 1 shares that cycle; bytes 2..4 fill
      // the FIFO and bytes 5..7 arrive long before the first dual write finishes
      for (int i = 0; i < 8; i++) begin
         a = (25'(i) << 14) | 25'(i + 16);
         send_byte(8'h01, a, 8'h90 + 8'(i), (i < 5), 9'h040 + 9'(i), 1);
      end
      end_wr();
      drain("ovf");
      checks++;
      if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b required 1", overflow); end
      checks++;
      if (wr_seen - w0 != 10) begin errors++; $display("FAIL ovf_count: got %0d writes required 10", wr_seen - w0); end
   endtask

   task automatic test_load_done();
      int l0;
      l0 = ld_count;
      // falling edge then a new download before the drain: no pulse
      send_byte(8'h00, 25'h0000000, 8'h01, 1, 9'h000, 0);
      send_byte(8'h00, 25'h0000001, 8'h02, 1, 9'h000, 0);
      end_wr();
      ioctl_download = 1'b0;
      repeat (2) @(posedge clk_sys);
      #1;
      ioctl_download = 1'b1;
      drain("ld_cancel");
      checks++;
      if (ld_count != l0) begin errors++; $display("FAIL ld_cancel: got %0d pulses required 0", ld_count - l0); end
      // falling edge while already drained
      ioctl_download = 1'b0;
      repeat (4) @(posedge clk_sys);
      #1;
      checks++;
      if (ld_count != l0 + 1) begin errors++; $display("FAIL ld_idle: got %0d pulses required 1", ld_count - l0); end
      ioctl_download = 1'b1;
      repeat (2) @(posedge clk_sys);
      #1;
      send_byte(8'h00, 25'h0004002, 8'h03, 1, 9'h100, 0);
      send_byte(8'h00, 25'h0004003, 8'h04, 1, 9'h100, 0);
      end_wr();
      ioctl_download = 1'b0;
      drain("ld_main");
      repeat (4) @(posedge clk_sys);
      #1;
      checks++;
      if (ld_count != l0 + 2) begin errors++; $display("FAIL ld_main_count: got %0d pulses required 1", ld_count - l0 - 1); end
      checks++;
      if (ld_cyc != commit_cyc + 1) begin
         errors++; $display("FAIL ld_main_cycle: got cycle %0d required %0d", ld_cyc, commit_cyc + 1);
      end
      ioctl_download = 1'b1;
      repeat (2) @(posedge clk_sys);
      #1;
   endtask

   task automatic test_reset_bank1();
      int b;
      int w0;
      bit saw_wr;
      exp_page = 9'h050;
      send_byte(8'h01, 25'h0000007, 8'hB1, 1, 9'h050, 1);
      send_byte(8'h01, 25'h0004007, 8'hB2, 1, 9'h051, 1);
      send_byte(8'h01, 25'h0008007, 8'hB3, 1, 9'h052, 1);
      end_wr();
      b = 0;
      do begin
         @(negedge clk_sys);
         b++;
      end while (!(boot_wr && boot_bank == 2'b01 && !ce_ref) && b < 300);
      checks++;
      if (b >= 300) begin errors++; $display("FAIL rst_bank1_seen: timeout, bank %b required 01", boot_bank); end
      #1;
      reset = 1'b1;
      sb.delete();
      @(negedge clk_sys);
      checks++;
      if (boot_wr !== 1'b0) begin errors++; $display("FAIL rst_boot_wr: got %b required 0", boot_wr); end
      checks++;
      if (rom_map !== '0) begin errors++; $display("FAIL rst_rom_map: got %h required 0", rom_map); end
      checks++;
      if ({ioctl_wait, overflow} !== 2'b00) begin
         errors++; $display("FAIL rst_wait_ovf: got %b required 00", {ioctl_wait, overflow});
      end
      @(posedge clk_sys);
      #1;
      reset = 1'b0;
      w0 = wr_seen;
      saw_wr = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk_sys);
         if (boot_wr) saw_wr = 1;
      end
      checks++;
      if (saw_wr || wr_seen != w0) begin
         errors++; $display("FAIL rst_fifo_empty: got boot_wr=%b after reset required 0", saw_wr);
      end
   endtask

   initial begin
      test_reset();
      test_expansion();
      test_system_image();
      test_plus();
      test_ignored();
      test_burst_obey();
      test_burst_overflow();
      test_load_done();
      test_reset_bank1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
